fifo_rd_stream: RTL and testbench

- Synthesizable read-side drainer for async_fifo. Runs in the read clock domain and pops words through the FIFO read port (empty/ren/rdata).
- Re-presents the words on a downstream valid/ready stream, with a 2-entry elastic buffer so ready backpressure never causes a FIFO underflow or a lost word.
- Supports both FIFO read modes: first-word fall-through and registered read.
- Provides a flush command that pulses the FIFO read-pointer clear and discards all buffered and in-flight words.

---
 rtl/fifo_rd_stream.sv | 136 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drainer for async_fifo.
// Pops words from the FIFO read port into a 2-entry elastic buffer and
// presents the buffer head on a valid/ready stream. The buffer absorbs
// downstream backpressure. Supports fall-through and registered FIFO reads.
// Optional: define FIFO_RD_STALL_CNT_EN to add the stall_cnt output.
module fifo_rd_stream #(
  parameter int    DSIZE       = 8,
  parameter string FALLTHROUGH = "TRUE",
  parameter int    CNT_W       = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             fifo_ren,
  output logic             fifo_rptr_clr,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy
`ifdef FIFO_RD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam bit FT = (FALLTHROUGH == "TRUE");

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state;
  logic [1:0]       occ;
  logic             inflight;
  logic [DSIZE-1:0] head_q;
  logic [DSIZE-1:0] tail_q;
  logic [1:0]       in_use;
  logic             cap;
  logic             xfer;

  // Pops are decided from registered occupancy only, so a word is only
  // requested when a buffer slot is guaranteed to be free for it.
  assign in_use        = occ + {1'b0, inflight};
  assign fifo_ren      = (state == RUN) && enable && !fifo_empty &&
                         (in_use < 2'd2) && !flush;
  // Fall-through data lands on the pop edge; registered data one cycle later.
  assign cap           = !flush && (FT ? fifo_ren : inflight);
  assign xfer          = out_valid && out_ready && !flush;
  assign out_valid     = (occ != 2'd0);
  assign out_data      = head_q;
  assign busy          = out_valid || inflight;
  assign fifo_rptr_clr = (state == FLUSH);

  // Control state: flush overrides everything and lasts one cycle.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= IDLE;
    end else if (flush) begin
      state <= FLUSH;
    end else begin
      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable && !inflight) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered-read tracking: a pop leaves one word in flight for a cycle.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      inflight <= 1'b0;
    end else if (flush || FT) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_ren;
    end
  end

  // Two-entry in-order buffer; head_q is always the oldest word.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ    <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      case ({cap, xfer})
        2'b10: begin
          if (occ == 2'd0) head_q <= fifo_rdata;
          else             tail_q <= fifo_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_q <= fifo_rdata;
          end else begin
            head_q <= tail_q;
            tail_q <= fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Accepted-word counter; wraps naturally and survives flush.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      word_cnt <= '0;
    end else if (xfer) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

`ifdef FIFO_RD_STALL_CNT_EN
  // Saturating count of cycles where a word waits on the downstream.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: one fall-through and one registered-read
// instance share enable/flush/out_ready; each has its own FIFO model and a
// queue-based reference of the stream buffer.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_FLUSH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [1:0]    empty = 2'b11;
  logic [1:0]    ren;
  logic [1:0]    clr;
  logic [1:0]    valid;
  logic [1:0]    busy;
  logic [DW-1:0] rdata [2];
  logic [DW-1:0] data  [2];
  logic [CW-1:0] cnt   [2];
`ifdef FIFO_RD_STALL_CNT_EN
  logic [CW-1:0] stall [2];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // FIFO models and registered-read output register
  logic [DW-1:0] fq [2][$];
  logic [DW-1:0] rreg = '0;

  // Reference model
  int            mst    [2];
  logic [DW-1:0] mq     [2][$];
  bit            minfl  [2];
  logic [CW-1:0] mcnt   [2];
  logic [CW-1:0] mstall [2];

  int cyc = 0;
  bit track = 1'b0;
  int first_ren [2];
  int first_val [2];
  int last_val  [2];
  logic [CW-1:0] saved_cnt [2];

  always #5 clk = ~clk;

  fifo_rd_stream #(.DSIZE(DW), .FALLTHROUGH("TRUE"), .CNT_W(CW)) u_ft (
    .rclk(clk), .rrst_n(rst_n), .enable(enable), .flush(flush),
    .fifo_empty(empty[0]), .fifo_rdata(rdata[0]), .fifo_ren(ren[0]),
    .fifo_rptr_clr(clr[0]), .out_valid(valid[0]), .out_data(data[0]),
    .out_ready(out_ready), .word_cnt(cnt[0]), .busy(busy[0])
`ifdef FIFO_RD_STALL_CNT_EN
    , .stall_cnt(stall[0])
`endif
  );

  fifo_rd_stream #(.DSIZE(DW), .FALLTHROUGH("FALSE"), .CNT_W(CW)) u_rd (
    .rclk(clk), .rrst_n(rst_n), .enable(enable), .flush(flush),
    .fifo_empty(empty[1]), .fifo_rdata(rdata[1]), .fifo_ren(ren[1]),
    .fifo_rptr_clr(clr[1]), .out_valid(valid[1]), .out_data(data[1]),
    .out_ready(out_ready), .word_cnt(cnt[1]), .busy(busy[1])
`ifdef FIFO_RD_STALL_CNT_EN
    , .stall_cnt(stall[1])
`endif
  );

  task automatic chk(input string tag, input int m, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @cyc %0d: got 0x%0h, expected 0x%0h", tag, m, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mst[m] = S_IDLE;
      mq[m].delete();
      minfl[m] = 1'b0;
      mcnt[m] = '0;
      mstall[m] = '0;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, "_ren"},   m, 32'(ren[m]),   32'(0));
      chk({tag, "_clr"},   m, 32'(clr[m]),   32'(0));
      chk({tag, "_valid"}, m, 32'(valid[m]), 32'(0));
      chk({tag, "_data"},  m, 32'(data[m]),  32'(0));
      chk({tag, "_cnt"},   m, 32'(cnt[m]),   32'(0));
      chk({tag, "_busy"},  m, 32'(busy[m]),  32'(0));
`ifdef FIFO_RD_STALL_CNT_EN
      chk({tag, "_stall"}, m, 32'(stall[m]), 32'(0));
`endif
    end
  endtask

  // One cycle: drive inputs at negedge, check outputs, advance the models.
  task automatic step(input bit en, input bit fl, input bit rdy, input int npush);
    logic [DW-1:0] w;
    logic [DW-1:0] cw;
    bit e_ren;
    bit e_val;
    bit cap;
    @(negedge clk);
    enable = en;
    flush = fl;
    out_ready = rdy;
    for (int i = 0; i < npush; i++) begin
      w = DW'($urandom);
      fq[0].push_back(w);
      fq[1].push_back(w);
    end
    for (int m = 0; m < 2; m++) empty[m] = (fq[m].size() == 0);
    rdata[0] = empty[0] ? '0 : fq[0][0];
    rdata[1] = rreg;
    #1;
    cyc++;
    for (int m = 0; m < 2; m++) begin
      e_ren = (mst[m] == S_RUN) && en && !empty[m] &&
              ((mq[m].size() + int'(minfl[m])) < 2) && !fl;
      e_val = (mq[m].size() != 0);
      chk("fifo_ren", m, 32'(ren[m]), 32'(e_ren));
      chk("ren_while_empty", m, 32'(ren[m] & empty[m]), 32'(0));
      chk("out_valid", m, 32'(valid[m]), 32'(e_val));
      if (e_val) chk("out_data", m, 32'(data[m]), 32'(mq[m][0]));
      chk("word_cnt", m, 32'(cnt[m]), 32'(mcnt[m]));
      chk("busy", m, 32'(busy[m]), 32'(e_val || minfl[m]));
      chk("rptr_clr", m, 32'(clr[m]), 32'(mst[m] == S_FLUSH));
`ifdef FIFO_RD_STALL_CNT_EN
      chk("stall_cnt", m, 32'(stall[m]), 32'(mstall[m]));
`endif
      if (track) begin
        if (ren[m] && first_ren[m] < 0) first_ren[m] = cyc;
        if (valid[m]) begin
          if (first_val[m] < 0) first_val[m] = cyc;
          last_val[m] = cyc;
        end
      end
      // word arriving at the buffer this cycle
      cap = 1'b0;
      cw = '0;
      if (m == 0) begin
        if (e_ren) begin cap = 1'b1; cw = fq[0][0]; end
      end else if (minfl[1]) begin
        cap = 1'b1;
        cw = rdata[1];
      end
      if (fl) begin
        mq[m].delete();
        minfl[m] = 1'b0;
        mstall[m] = '0;
        mst[m] = S_FLUSH;
      end else begin
        if (e_val && rdy) begin
          void'(mq[m].pop_front());
          mcnt[m] = mcnt[m] + 1'b1;
        end else if (e_val && !rdy && mstall[m] != '1) begin
          mstall[m] = mstall[m] + 1'b1;
        end
        if (cap) begin
          chk("buffer_room", m, 32'(mq[m].size() < 2), 32'(1));
          mq[m].push_back(cw);
        end
        case (mst[m])
          S_IDLE:  if (en) mst[m] = S_RUN;
          S_RUN:   if (!en && !minfl[m]) mst[m] = S_IDLE;
          default: mst[m] = S_IDLE;
        endcase
        minfl[m] = (m == 1) && e_ren;
      end
      // FIFO reacts to what the DUT actually drove
      if (clr[m]) begin
        fq[m].delete();
      end else if (ren[m] && fq[m].size() != 0) begin
        w = fq[m].pop_front();
        if (m == 1) rreg = w;
      end
    end
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++)
      step(($urandom % 8) != 0, ($urandom % 40) == 0, ($urandom % 3) != 0,
           (($urandom % 4) == 0) ? int'($urandom % 3) : 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    enable = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    for (int m = 0; m < 2; m++) begin
      rdata[m] = '0;
      first_ren[m] = -1;
      first_val[m] = -1;
      last_val[m] = -1;
    end
    #3;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Preloaded burst, downstream always ready
    track = 1'b1;
    step(1'b0, 1'b0, 1'b1, 8);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 1'b1, 0);
    track = 1'b0;
    chk("ft_first_latency", 0, 32'(first_val[0] - first_ren[0]), 32'(1));
    chk("rd_first_latency", 1, 32'(first_val[1] - first_ren[1]), 32'(2));
    chk("ft_back_to_back", 0, 32'(last_val[0] - first_val[0]), 32'(7));
    for (int m = 0; m < 2; m++) begin
      chk("burst_cnt", m, 32'(cnt[m]), 32'(8));
      chk("burst_idle", m, 32'(busy[m]), 32'(0));
    end

    // Backpressure with 5 words, then release
    step(1'b1, 1'b0, 1'b0, 5);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 0);
    for (int m = 0; m < 2; m++) chk("bp_ren_stopped", m, 32'(ren[m]), 32'(0));
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 0);
    for (int m = 0; m < 2; m++) chk("bp_cnt", m, 32'(cnt[m]), 32'(13));

    // Flush with a full buffer and reads in flight
    step(1'b1, 1'b0, 1'b0, 6);
    step(1'b1, 1'b0, 1'b0, 0);
    for (int m = 0; m < 2; m++) saved_cnt[m] = cnt[m];
    step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 0);
    for (int m = 0; m < 2; m++) chk("flush_keeps_cnt", m, 32'(cnt[m]), 32'(saved_cnt[m]));

    // enable dropped while a read is in flight
    step(1'b1, 1'b0, 1'b1, 6);
    step(1'b1, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 0);
    for (int m = 0; m < 2; m++) chk("disabled_no_ren", m, 32'(ren[m]), 32'(0));

    rand_steps(1500);
    step(1'b1, 1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    mid_reset();
    rand_steps(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
